// File: rtl/sprite_palette_arbiter_pkg.sv
// Shared types and defaults for the sprite palette arbiter.
// Palette index/colour types plus winner-width helper.
package sprite_pkg;

    typedef logic [3:0]  pal_idx_t;
    typedef logic [11:0] rgb12_t;

    localparam pal_idx_t TRANSPARENT_IDX_DEF = 4'd0;
    localparam rgb12_t   BG_RGB_DEF          = 12'h000;

    function automatic int win_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_palette_arbiter_if.sv
// Pixel-side bundle of the sprite palette arbiter.
// slave = arbiter, master = sprite readers / palette / VGA mux.
interface sprite_palette_arbiter_if
    import sprite_pkg::*;
#(
    parameter int NUM_SPRITES = 4
);
    localparam int WW = win_w(NUM_SPRITES);

    logic                     pixel_valid;
    logic                     frame_start;
    logic [NUM_SPRITES-1:0]   spr_active;
    logic [4*NUM_SPRITES-1:0] spr_index;
    pal_idx_t                 pal_index;
    rgb12_t                   pal_rgb;
    logic [3:0]               red;
    logic [3:0]               green;
    logic [3:0]               blue;
    logic                     rgb_valid;
    logic [WW-1:0]            winner;
    logic [NUM_SPRITES-1:0]   collision;
    logic [NUM_SPRITES-1:0]   collision_frm;

    modport master (
        output pixel_valid, frame_start, spr_active, spr_index, pal_rgb,
        input  pal_index, red, green, blue, rgb_valid, winner,
               collision, collision_frm
    );

    modport slave (
        input  pixel_valid, frame_start, spr_active, spr_index, pal_rgb,
        output pal_index, red, green, blue, rgb_valid, winner,
               collision, collision_frm
    );

endinterface

// File: rtl/sprite_palette_arbiter_select.sv
// Combinational layer priority: opaque mask, lowest-index winner
// and a flag for two or more opaque layers.
module sprite_priority_select
    import sprite_pkg::*;
#(
    parameter int       NUM_SPRITES     = 4,
    parameter pal_idx_t TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
    parameter int       WW              = win_w(NUM_SPRITES)
) (
    input  logic [NUM_SPRITES-1:0]   spr_active,
    input  logic [4*NUM_SPRITES-1:0] spr_index,
    output logic [NUM_SPRITES-1:0]   opaque,
    output logic                     hit,
    output logic                     multi,
    output pal_idx_t                 win_idx,
    output logic [WW-1:0]            win
);

    always_comb begin
        opaque = '0;
        for (int k = 0; k < NUM_SPRITES; k++) begin
            opaque[k] = spr_active[k] &&
                        (spr_index[4*k +: 4] != TRANSPARENT_IDX);
        end
    end

    // Scan from the bottom layer up so the lowest opaque index wins.
    always_comb begin
        win     = '0;
        win_idx = TRANSPARENT_IDX;
        for (int k = NUM_SPRITES - 1; k >= 0; k--) begin
            if (opaque[k]) begin
                win     = WW'(k);
                win_idx = spr_index[4*k +: 4];
            end
        end
    end

    assign hit   = |opaque;
    assign multi = (opaque & (opaque - 1'b1)) != '0;

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Two-stage sprite-to-palette pipeline with per-frame collision masks.
// Stage 1 drives the shared palette; stage 2 registers the colour.
module sprite_palette_arbiter
    import sprite_pkg::*;
#(
    parameter int       NUM_SPRITES     = 4,
    parameter pal_idx_t TRANSPARENT_IDX = TRANSPARENT_IDX_DEF,
    parameter rgb12_t   BG_RGB          = BG_RGB_DEF
) (
    input logic                     Clk,
    input logic                     Reset_n,
    sprite_palette_arbiter_if.slave bus
);

    localparam int WW = win_w(NUM_SPRITES);

    logic [NUM_SPRITES-1:0] opaque;
    logic                   hit;
    logic                   multi;
    pal_idx_t               win_idx;
    logic [WW-1:0]          win;

    logic                   s1_valid;
    logic                   s1_hit;
    pal_idx_t               s1_idx;
    logic [WW-1:0]          s1_win;

    rgb12_t                 rgb_q;
    rgb12_t                 rgb_next;
    logic                   rgb_valid_q;
    logic [WW-1:0]          winner_q;

    logic [NUM_SPRITES-1:0] coll_q;
    logic [NUM_SPRITES-1:0] coll_frm_q;
    logic [NUM_SPRITES-1:0] new_bits;

    sprite_priority_select #(
        .NUM_SPRITES     (NUM_SPRITES),
        .TRANSPARENT_IDX (TRANSPARENT_IDX),
        .WW              (WW)
    ) u_select (
        .spr_active (bus.spr_active),
        .spr_index  (bus.spr_index),
        .opaque     (opaque),
        .hit        (hit),
        .multi      (multi),
        .win_idx    (win_idx),
        .win        (win)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_idx   <= TRANSPARENT_IDX;
            s1_win   <= '0;
        end else begin
            s1_valid <= bus.pixel_valid;
            s1_hit   <= hit;
            s1_idx   <= win_idx;
            s1_win   <= win;
        end
    end

    // Blanked pixels emit black regardless of any opaque layer.
    always_comb begin
        rgb_next = '0;
        if (s1_valid) begin
            rgb_next = s1_hit ? bus.pal_rgb : BG_RGB;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            winner_q    <= '0;
        end else begin
            rgb_q       <= rgb_next;
            rgb_valid_q <= s1_valid;
            winner_q    <= s1_win;
        end
    end

    assign new_bits = (bus.pixel_valid && multi) ? opaque : '0;

    // A frame_start edge clears first, so same-cycle hits survive.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            coll_q     <= '0;
            coll_frm_q <= '0;
        end else begin
            coll_q <= (bus.frame_start ? '0 : coll_q) | new_bits;
            if (bus.frame_start) begin
                coll_frm_q <= coll_q;
            end
        end
    end

    assign bus.pal_index     = s1_idx;
    assign bus.red           = rgb_q[11:8];
    assign bus.green         = rgb_q[7:4];
    assign bus.blue          = rgb_q[3:0];
    assign bus.rgb_valid     = rgb_valid_q;
    assign bus.winner        = winner_q;
    assign bus.collision     = coll_q;
    assign bus.collision_frm = coll_frm_q;

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Self-checking bench: directed scenarios plus random streaming
// against a per-pixel reference model with a 2-deep result history.
module tb_sprite_palette_arbiter;

    logic Clk;
    logic Reset_n;

    sprite_palette_arbiter_if #(.NUM_SPRITES(4)) bus ();

    sprite_palette_arbiter #(
        .NUM_SPRITES     (4),
        .TRANSPARENT_IDX (4'd0),
        .BG_RGB          (12'h000)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [11:0] lut(input logic [3:0] i);
        if (i == 4'd1) return 12'hFFF;
        return {i, 4'hF - i, i ^ 4'hA};
    endfunction

    assign bus.pal_rgb = lut(bus.pal_index);

    typedef struct {
        logic        v;
        logic [11:0] rgb;
        logic [1:0]  win;
        logic [3:0]  idx;
    } px_t;

    px_t        hist[$];
    logic [3:0] m_coll;
    logic [3:0] m_frm;
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        px_t z;
        z.v = 1'b0; z.rgb = '0; z.win = '0; z.idx = '0;
        hist.delete();
        hist.push_front(z);
        hist.push_front(z);
        m_coll = '0;
        m_frm  = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pal_index"}, 16'(bus.pal_index), 16'(hist[0].idx));
        chk({tag, ".rgb"}, 16'({bus.red, bus.green, bus.blue}),
            16'(hist[1].rgb));
        chk({tag, ".rgb_valid"}, 16'(bus.rgb_valid), 16'(hist[1].v));
        chk({tag, ".winner"}, 16'(bus.winner), 16'(hist[1].win));
        chk({tag, ".collision"}, 16'(bus.collision), 16'(m_coll));
        chk({tag, ".collision_frm"}, 16'(bus.collision_frm), 16'(m_frm));
    endtask

    // One pixel: drive, predict from the rules, clock, compare.
    task automatic step(input logic pv, input logic fs,
                        input logic [3:0] act, input logic [15:0] idx,
                        input string tag);
        px_t        e;
        int         w;
        int         n;
        logic [3:0] opq;
        bus.pixel_valid = pv;
        bus.frame_start = fs;
        bus.spr_active  = act;
        bus.spr_index   = idx;
        w   = -1;
        n   = 0;
        opq = '0;
        for (int k = 0; k < 4; k++) begin
            if (act[k] && idx[4*k +: 4] != 4'd0) begin
                opq[k] = 1'b1;
                n++;
                if (w < 0) w = k;
            end
        end
        e.v   = pv;
        e.idx = (w >= 0) ? idx[4*w +: 4] : 4'd0;
        e.win = (w >= 0) ? 2'(w) : 2'd0;
        e.rgb = !pv ? 12'h000 : ((w >= 0) ? lut(e.idx) : 12'h000);
        hist.push_front(e);
        if (hist.size() > 4) void'(hist.pop_back());
        if (fs) m_frm = m_coll;
        m_coll = (fs ? 4'd0 : m_coll) | ((pv && n >= 2) ? opq : 4'd0);
        @(posedge Clk);
        #1;
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".pal_index"}, 16'(bus.pal_index), 16'h0);
        chk({tag, ".rgb"}, 16'({bus.red, bus.green, bus.blue}), 16'h0);
        chk({tag, ".rgb_valid"}, 16'(bus.rgb_valid), 16'h0);
        chk({tag, ".winner"}, 16'(bus.winner), 16'h0);
        chk({tag, ".collision"}, 16'(bus.collision), 16'h0);
        chk({tag, ".collision_frm"}, 16'(bus.collision_frm), 16'h0);
    endtask

    function automatic logic [15:0] rnd_idx();
        logic [15:0] r;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = ($urandom_range(0, 9) < 3) ? 4'd0
                                                     : 4'($urandom);
        end
        return r;
    endfunction

    initial begin
        Reset_n         = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.frame_start = 1'b0;
        bus.spr_active  = '0;
        bus.spr_index   = '0;

        for (int i = 0; i < 4; i++) begin
            @(posedge Clk);
            #1;
            bus.pixel_valid = 1'($urandom);
            bus.frame_start = 1'($urandom);
            bus.spr_active  = 4'($urandom);
            bus.spr_index   = 16'($urandom);
        end
        @(posedge Clk);
        #1;
        check_zero("reset");
        #2;
        Reset_n = 1'b1;
        model_reset();

        step(1'b1, 1'b0, 4'b0110, 16'h0530, "prio0");
        chk("prio.pal_index_c", 16'(bus.pal_index), 16'h3);
        chk("first.rgb_valid_lo", 16'(bus.rgb_valid), 16'h0);
        step(1'b1, 1'b0, 4'b0000, 16'h0000, "prio1");
        chk("prio.rgb_c", 16'({bus.red, bus.green, bus.blue}),
            16'(lut(4'd3)));
        chk("prio.winner_c", 16'(bus.winner), 16'h1);
        chk("first.rgb_valid_hi", 16'(bus.rgb_valid), 16'h1);

        step(1'b0, 1'b1, 4'b0000, 16'h0000, "clr");
        chk("clr.collision_c", 16'(bus.collision), 16'h0);
        step(1'b1, 1'b0, 4'b0011, 16'h0010, "transp0");
        step(1'b1, 1'b0, 4'b1111, 16'h0000, "transp1");
        chk("transp.rgb_c", 16'({bus.red, bus.green, bus.blue}),
            16'hFFF);
        chk("transp.winner_c", 16'(bus.winner), 16'h1);
        step(1'b1, 1'b0, 4'b0000, 16'h0000, "transp2");
        chk("allzero.rgb_c", 16'({bus.red, bus.green, bus.blue}),
            16'h000);
        chk("allzero.coll_c", 16'(bus.collision), 16'h0);

        step(1'b1, 1'b0, 4'b0101, 16'h0702, "coll0");
        chk("coll.set_c", 16'(bus.collision), 16'h5);
        step(1'b1, 1'b0, 4'b0010, 16'h0040, "coll1");
        chk("coll.sticky_c", 16'(bus.collision), 16'h5);
        step(1'b0, 1'b1, 4'b0000, 16'h0000, "coll2");
        chk("coll.frm_c", 16'(bus.collision_frm), 16'h5);
        chk("coll.clr_c", 16'(bus.collision), 16'h0);

        step(1'b1, 1'b0, 4'b0011, 16'h0021, "sim0");
        step(1'b1, 1'b1, 4'b1010, 16'h6040, "sim1");
        chk("sim.coll_c", 16'(bus.collision), 16'hA);
        chk("sim.frm_c", 16'(bus.collision_frm), 16'h3);
        step(1'b1, 1'b1, 4'b0001, 16'h0009, "sim2");
        chk("fs2.frm_c", 16'(bus.collision_frm), 16'hA);
        chk("fs2.coll_c", 16'(bus.collision), 16'h0);

        for (int i = 0; i < 640; i++) begin
            step(1'($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 99) < 2),
                 4'($urandom), rnd_idx(), "stream");
        end

        step(1'b1, 1'b0, 4'b1111, 16'h3456, "mid0");
        step(1'b1, 1'b0, 4'b1111, 16'h3456, "mid1");
        #2;
        Reset_n = 1'b0;
        #1;
        check_zero("midreset");
        @(posedge Clk);
        #2;
        Reset_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 4'b1000, 16'hC000, "post0");
        step(1'b1, 1'b0, 4'b0000, 16'h0000, "post1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
